zeta_addr_gen: RTL and testbench
================================

ZETA_ADDR_GEN -- requirements
Module: zeta_addr_gen

Interface
REQ-001 The block SHALL have parameter STAGE, default 1, giving the NTT stage served (1..`NTT_STAGE_CNT-1) and the zeta table size 2^STAGE.
REQ-002 The block SHALL have parameter L, default `NTT_STAGE_CNT, giving log2 of polynomial length N; beats per block B = 2^(L-2), two butterflies per beat.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: one-cycle request to begin a run.
REQ-006 The block SHALL have port num_blocks, input, 8 bits: number of N-point blocks in the run, sampled with start.
REQ-007 The block SHALL have port busy, output, 1 bit: high from the cycle after start is accepted until done.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse at end of run.
REQ-009 The block SHALL have port rom_addr[2], output, L-1 bits each: zeta ROM read addresses for lanes 0 and 1, driven to the stage-STAGE zeta ROM with 1-cycle registered read.
REQ-010 The block SHALL have port zeta_valid, output, 1 bit: ROM data currently on rom_data belongs to a live beat.
REQ-011 The block SHALL have port zeta_ready, input, 1 bit: butterfly consumes the beat when zeta_valid && zeta_ready.
REQ-012 The block SHALL have port zeta_last, output, 1 bit: qualifies the final beat of the run.
REQ-013 The block SHALL have port zeta_beat, output, L-2 bits: beat index within block for the beat under zeta_valid.

Function
REQ-014 The block SHALL use FSM states IDLE, RUN, FLUSH.
- IDLE -> RUN on start with num_blocks != 0.
- IDLE stays on start with num_blocks == 0; done pulses next cycle.
- RUN -> FLUSH when final beat address issued.
- FLUSH -> IDLE when final beat accepted.
REQ-015 The block SHALL ignore start while not IDLE.
REQ-016 The block SHALL keep a beat counter cnt (L-2 bits) and a block counter (8 bits); cnt wraps B-1 -> 0 and increments block counter.
REQ-017 The block SHALL issue a beat in RUN when !zeta_valid || zeta_ready; issue advances cnt.
REQ-018 The block SHALL compute lane j address as: b = 2*cnt + j; index = b >> (L-1-STAGE), truncated to STAGE bits, zero-extended to L-1 bits.
REQ-019 The block SHALL latch zeta_valid <= issue on every cycle where !zeta_valid || zeta_ready; otherwise zeta_valid holds.
REQ-020 The block SHALL drive, during stall (zeta_valid && !zeta_ready), rom_addr = address pair of the displayed beat (saved copy), so ROM output stays stable.
REQ-021 The block SHALL make zeta_beat and zeta_last register with zeta_valid and hold during stall.
REQ-022 Latency: start sampled cycle t; beat-0 address at t+1; zeta_valid first high at t+2 when zeta_ready held high.
REQ-023 Throughput: one beat per cycle with zeta_ready held high; num_blocks*B beats total, no bubbles across block boundaries.
REQ-024 The block SHALL pulse done the cycle after final beat accepted; busy falls the same cycle.

Reset
REQ-025 The block SHALL, on rst_n low (asynchronously, any state): enter IDLE; set cnt, block counter, saved addresses, rom_addr = 0; set zeta_valid, zeta_last, busy, done = 0; set zeta_beat = 0.
REQ-026 The block SHALL not resume a run interrupted by reset; a new start is required.

Verification
REQ-027 Scenario: L=8, STAGE=3, num_blocks=1, zeta_ready=1 -> 64 beats.
- beat 0 addr (0,0), beat 7 (0,0), beat 8 (1,1), beat 63 (7,7).
- zeta_last on beat 63; done one cycle later.
REQ-028 Scenario: L=8, STAGE=7, num_blocks=2 -> beat 5 addr (10,11), beat 63 (126,127); 128 beats contiguous; cnt wraps to 0 at block 2 with addr (0,1).
REQ-029 Scenario: zeta_ready low 3 cycles while beat 8 displayed (STAGE=3) -> rom_addr stays (1,1), zeta_beat stays 8, zeta_valid stays 1; beat 9 follows on release, none lost or duplicated.
REQ-030 Scenario: start with num_blocks=0 -> no zeta_valid, done pulse next cycle, busy never high.
REQ-031 Scenario: rst_n low mid-run at beat 20 -> all outputs 0 immediately (asynchronously); later start gives beat 0 again.
REQ-032 Scenario: start re-asserted while busy -> ignored; beat count of run unchanged.

Source files
------------

// File: rtl/zeta_addr_gen_if.sv
// rtl/zeta_addr_gen_if.sv - run-control and zeta beat bus between sequencer and NTT butterfly
// Ports (slave = generator side):
//   start, num_blocks      run request and block count, sampled together
//   busy, done             run status, done is a one-cycle pulse
//   rom_addr[2]            lane 0/1 zeta ROM addresses (ROM has 1-cycle registered read)
//   zeta_valid/zeta_ready  beat handshake, zeta_last marks final beat, zeta_beat is beat index
`ifndef NTT_STAGE_CNT
`define NTT_STAGE_CNT 8
`endif

interface zeta_addr_gen_if #(
    parameter int L = `NTT_STAGE_CNT
);
    logic           start;
    logic [7:0]     num_blocks;
    logic           busy;
    logic           done;
    logic [L-2:0]   rom_addr [2];
    logic           zeta_valid;
    logic           zeta_ready;
    logic           zeta_last;
    logic [L-3:0]   zeta_beat;

    modport master (
        output start, num_blocks, zeta_ready,
        input  busy, done, rom_addr, zeta_valid, zeta_last, zeta_beat
    );

    modport slave (
        input  start, num_blocks, zeta_ready,
        output busy, done, rom_addr, zeta_valid, zeta_last, zeta_beat
    );
endinterface

// File: rtl/zeta_addr_gen.sv
// rtl/zeta_addr_gen.sv - zeta ROM address sequencer for one NTT stage, two butterflies per beat
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    zeta_addr_gen_if.slave: start/num_blocks in, busy/done out,
//          rom_addr[2] to the stage zeta ROM, zeta_valid/ready/last/beat beat stream
`ifndef NTT_STAGE_CNT
`define NTT_STAGE_CNT 8
`endif

module zeta_addr_gen #(
    parameter int STAGE = 1,
    parameter int L     = `NTT_STAGE_CNT
) (
    input  logic            clk,
    input  logic            rst_n,
    zeta_addr_gen_if.slave  bus
);
    localparam int AW    = L - 1;
    localparam int BW    = L - 2;
    localparam int SHIFT = L - 1 - STAGE;
    localparam logic [BW-1:0] CNT_LAST = '1;
    localparam logic [BW-1:0] CNT_ONE  = BW'(1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t          state_q;
    logic [BW-1:0]   cnt_q;
    logic [7:0]      blk_q;
    logic [7:0]      nblk_q;
    logic [AW-1:0]   saved_q [2];
    logic            valid_q;
    logic            last_q;
    logic [BW-1:0]   beat_q;
    logic            busy_q;
    logic            done_q;

    logic            advance;
    logic            issue;
    logic            final_beat;
    logic [AW-1:0]   issue_addr [2];

    // Butterfly index b = 2*cnt + lane; the table index is its top STAGE bits.
    // After the shift the upper SHIFT bits are already zero, which gives the
    // truncation to STAGE bits and the zero extension in one step.
    function automatic logic [AW-1:0] lane_addr(input logic [BW-1:0] c, input logic lane);
        logic [AW-1:0] b;
        b = {c, lane};
        return b >> SHIFT;
    endfunction

    // The display register can take a new beat when empty or being consumed.
    assign advance    = !valid_q || bus.zeta_ready;
    assign issue      = (state_q == RUN) && advance;
    assign final_beat = (cnt_q == CNT_LAST) && (blk_q == nblk_q - 8'd1);

    always_comb begin
        issue_addr[0] = lane_addr(cnt_q, 1'b0);
        issue_addr[1] = lane_addr(cnt_q, 1'b1);
    end

    // When not issuing, replay the displayed beat's address so the ROM's
    // registered output stays put during a stall.
    always_comb begin
        for (int j = 0; j < 2; j++) begin
            bus.rom_addr[j] = issue ? issue_addr[j] : saved_q[j];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            blk_q      <= '0;
            nblk_q     <= '0;
            saved_q[0] <= '0;
            saved_q[1] <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            beat_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;

            // ROM data for an issued beat appears one cycle later, so the
            // beat qualifiers are registered alongside it.
            if (advance) begin
                valid_q <= issue;
                if (issue) begin
                    beat_q <= cnt_q;
                    last_q <= final_beat;
                end else begin
                    last_q <= 1'b0;
                end
            end

            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.num_blocks != 8'd0) begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                            cnt_q   <= '0;
                            blk_q   <= '0;
                            nblk_q  <= bus.num_blocks;
                        end else begin
                            done_q  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (issue) begin
                        saved_q[0] <= issue_addr[0];
                        saved_q[1] <= issue_addr[1];
                        cnt_q      <= cnt_q + CNT_ONE;
                        if (cnt_q == CNT_LAST) begin
                            blk_q <= blk_q + 8'd1;
                        end
                        if (final_beat) begin
                            state_q <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    // Only the final beat can be in flight here.
                    if (valid_q && bus.zeta_ready && last_q) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.zeta_valid = valid_q;
    assign bus.zeta_last  = last_q;
    assign bus.zeta_beat  = beat_q;
endmodule

// File: tb/tb_zeta_addr_gen.sv
// tb/tb_zeta_addr_gen.sv - directed self-checking bench for zeta_addr_gen (L=8, STAGE 3 and 7)
module tb_zeta_addr_gen;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    zeta_addr_gen_if #(.L(8)) i3 ();
    zeta_addr_gen_if #(.L(8)) i7 ();

    zeta_addr_gen #(.STAGE(3), .L(8)) u3 (.clk(clk), .rst_n(rst_n), .bus(i3.slave));
    zeta_addr_gen #(.STAGE(7), .L(8)) u7 (.clk(clk), .rst_n(rst_n), .bus(i7.slave));

    logic       sel;
    logic       start_r;
    logic       ready_r;
    logic [7:0] nb_r;

    assign i3.start      = start_r && !sel;
    assign i7.start      = start_r && sel;
    assign i3.num_blocks = nb_r;
    assign i7.num_blocks = nb_r;
    assign i3.zeta_ready = ready_r;
    assign i7.zeta_ready = ready_r;

    logic       s_valid, s_last, s_busy, s_done;
    logic [5:0] s_beat;
    logic [6:0] s_a0, s_a1;

    always_comb begin
        if (sel) begin
            s_valid = i7.zeta_valid; s_last = i7.zeta_last; s_busy = i7.busy;
            s_done  = i7.done; s_beat = i7.zeta_beat;
            s_a0    = i7.rom_addr[0]; s_a1 = i7.rom_addr[1];
        end else begin
            s_valid = i3.zeta_valid; s_last = i3.zeta_last; s_busy = i3.busy;
            s_done  = i3.done; s_beat = i3.zeta_beat;
            s_a0    = i3.rom_addr[0]; s_a1 = i3.rom_addr[1];
        end
    end

    int checks = 0;
    int errors = 0;
    int ck_idx [4];
    int ck_a0  [4];
    int ck_a1  [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic start_run(input logic s, input logic [7:0] n);
        sel     = s;
        nb_r    = n;
        start_r = 1'b1;
        @(negedge clk);
        start_r = 1'b0;
        chk("busy_after_start", s_busy, 1);
        chk("valid_not_yet", s_valid, 0);
    endtask

    // Follows one run; rom_addr is sampled after ready settles, and the
    // displayed beat's address is the one presented in the previous cycle.
    task automatic watch(input int exp_beats, input int stall_beat, input int restart_cyc);
        int count, bubbles, stall_left;
        bit started, finished;
        logic [6:0] p0, p1, c0, c1;
        count = 0; bubbles = 0; stall_left = 3; started = 0; finished = 0;
        #1;
        p0 = s_a0; p1 = s_a1;
        for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            @(negedge clk);
            if (cyc == restart_cyc) begin
                start_r = 1'b1;
                nb_r    = 8'd5;
            end else begin
                start_r = 1'b0;
            end
            ready_r = 1'b1;
            if (s_valid && !started) begin
                started = 1;
                chk("first_valid_cycle", cyc, 0);
            end
            if (s_valid && stall_beat >= 0 && count == stall_beat && stall_left > 0) begin
                ready_r = 1'b0;
                stall_left--;
            end
            #1;
            c0 = s_a0; c1 = s_a1;
            if (s_valid && !ready_r && stall_left < 2) begin
                // the only stall scenario holds beat 8 of STAGE 3: address (1,1)
                chk("stall_a0", c0, 1);
                chk("stall_a1", c1, 1);
                chk("stall_beat", s_beat, stall_beat);
            end
            if (s_valid && ready_r) begin
                chk("beat_idx", s_beat, count % 64);
                chk("last_flag", s_last, (count == exp_beats - 1));
                for (int k = 0; k < 4; k++) begin
                    if (ck_idx[k] == count) begin
                        chk("beat_a0", p0, ck_a0[k]);
                        chk("beat_a1", p1, ck_a1[k]);
                    end
                end
                count++;
                if (count == exp_beats) finished = 1;
            end else if (!s_valid && started) begin
                bubbles++;
            end
            p0 = c0; p1 = c1;
        end
        ready_r = 1'b1;
        chk("beats_total", count, exp_beats);
        chk("bubbles", bubbles, 0);
        @(negedge clk);
        chk("done_pulse", s_done, 1);
        chk("busy_fall", s_busy, 0);
        chk("valid_after", s_valid, 0);
        @(negedge clk);
        chk("done_clear", s_done, 0);
    endtask

    initial begin
        int hi;
        bit found;
        sel = 0; start_r = 0; ready_r = 1; nb_r = 0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            chk("rst_valid", s_valid, 0);
            chk("rst_busy", s_busy, 0);
            chk("rst_done", s_done, 0);
            chk("rst_a0", s_a0, 0);
            chk("rst_a1", s_a1, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // STAGE 3, one block, ready held high
        ck_idx = '{0, 7, 8, 63}; ck_a0 = '{0, 0, 1, 7}; ck_a1 = '{0, 0, 1, 7};
        start_run(1'b0, 8'd1);
        watch(64, -1, -1);

        // STAGE 3, stall 3 cycles on beat 8
        ck_idx = '{8, 9, 16, 63}; ck_a0 = '{1, 1, 2, 7}; ck_a1 = '{1, 1, 2, 7};
        start_run(1'b0, 8'd1);
        watch(64, 8, -1);

        // STAGE 3, start re-asserted while busy
        ck_idx = '{0, 7, 8, 63}; ck_a0 = '{0, 0, 1, 7}; ck_a1 = '{0, 0, 1, 7};
        start_run(1'b0, 8'd1);
        watch(64, -1, 10);

        // STAGE 7, two blocks
        ck_idx = '{5, 63, 64, 127}; ck_a0 = '{10, 126, 0, 126}; ck_a1 = '{11, 127, 1, 127};
        start_run(1'b1, 8'd2);
        watch(128, -1, -1);

        // num_blocks == 0
        sel = 0; nb_r = 8'd0; start_r = 1'b1;
        @(negedge clk);
        start_r = 1'b0;
        chk("zero_done", s_done, 1);
        chk("zero_busy", s_busy, 0);
        chk("zero_valid", s_valid, 0);
        hi = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (s_busy || s_valid || s_done) hi++;
        end
        chk("zero_quiet", hi, 0);

        // reset in the middle of a STAGE 7 run
        start_run(1'b1, 8'd2);
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (s_valid && s_beat == 6'd20) found = 1;
        end
        chk("reach_beat20", found, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", s_valid, 0);
        chk("arst_last", s_last, 0);
        chk("arst_busy", s_busy, 0);
        chk("arst_done", s_done, 0);
        chk("arst_beat", s_beat, 0);
        chk("arst_a0", s_a0, 0);
        chk("arst_a1", s_a1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("no_resume_valid", s_valid, 0);
        chk("no_resume_busy", s_busy, 0);
        ck_idx = '{0, 5, 20, 63}; ck_a0 = '{0, 10, 40, 126}; ck_a1 = '{1, 11, 41, 127};
        start_run(1'b1, 8'd1);
        watch(64, -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
